mem_exec_unit: RTL and testbench

- Consumer end of the memory issue path: takes the single uop issued per cycle by the memory issue queue, plus its PRF operand values.
- Computes the effective address and drives a valid/ready request to the data memory port.
- Waits for the load response, aligns and sign-extends load data, and returns a writeback/completion record to the PRF and ROB.
- Drives ex_busy back to the issue queue as issue backpressure.

---
 rtl/mem_exec_unit_pkg.sv | 45 ++++
 rtl/mem_exec_unit_align.sv | 49 ++++
 rtl/mem_exec_unit.sv | 146 ++++++++++++++
 tb/tb_mem_exec_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_exec_unit_pkg.sv
// Shared micro-op definitions for the memory execution path: access types,
// access sizes, the issued micro-op record and the execute-unit FSM states.
package mem_exec_unit_pkg;

  localparam int XLEN      = 32;
  localparam int ROB_IDX_W = 6;
  localparam int PREG_W    = 7;

  typedef enum logic [1:0] {
    MEM_NONE = 2'd0,
    MEM_LD   = 2'd1,
    MEM_ST   = 2'd2
  } mem_type_t;

  // Encoding follows the RISC-V funct3 of loads/stores.
  typedef enum logic [2:0] {
    MEM_B  = 3'd0,
    MEM_H  = 3'd1,
    MEM_W  = 3'd2,
    MEM_BU = 3'd4,
    MEM_HU = 3'd5
  } mem_size_t;

  typedef struct packed {
    logic                 valid;
    mem_type_t            mem_type;
    mem_size_t            mem_size;
    logic [XLEN-1:0]      imm;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PREG_W-1:0]    pdst;
  } micro_op_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    WB    = 3'd3,
    DRAIN = 3'd4
  } mem_exec_state_t;

  function automatic logic is_mem_op(mem_type_t t);
    return (t == MEM_LD) || (t == MEM_ST);
  endfunction

endpackage

// File: rtl/mem_exec_unit_align.sv
// Byte-lane steering for 32-bit memory accesses: store strobes and data
// replication, load extraction with sign/zero extension, misalignment check.
module mem_align_unit
  import mem_exec_unit_pkg::*;
(
  input  logic [1:0]      addr_lo,
  input  mem_size_t       mem_size,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_word,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned
);

  logic [XLEN-1:0] shifted;

  assign shifted = load_word >> {addr_lo, 3'b000};

  always_comb begin
    wstrb      = 4'b1111;
    wdata      = store_data;
    misaligned = 1'b0;
    case (mem_size)
      MEM_B, MEM_BU: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {(XLEN/8){store_data[7:0]}};
      end
      MEM_H, MEM_HU: begin
        wstrb      = 4'b0011 << addr_lo;
        wdata      = {(XLEN/16){store_data[15:0]}};
        misaligned = addr_lo[0];
      end
      default: misaligned = (addr_lo != 2'b00);
    endcase
  end

  always_comb begin
    load_data = shifted;
    case (mem_size)
      MEM_B:   load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      MEM_BU:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      MEM_H:   load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      MEM_HU:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_exec_unit.sv
// Memory execute stage: computes the effective address, runs one request on the
// data-memory port, waits for load data and emits a one-cycle writeback record.
module mem_exec_unit #(
  parameter int XLEN        = mem_exec_unit_pkg::XLEN,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                clear_en,
  input  mem_exec_unit_pkg::micro_op_t        uop_in,
  input  logic [XLEN-1:0]                     rs1_data,
  input  logic [XLEN-1:0]                     rs2_data,
  output logic                                ex_busy,
  output logic                                mem_req_valid,
  input  logic                                mem_req_ready,
  output logic                                mem_req_we,
  output logic [XLEN-1:0]                     mem_req_addr,
  output logic [XLEN-1:0]                     mem_req_wdata,
  output logic [3:0]                          mem_req_wstrb,
  input  logic                                mem_resp_valid,
  input  logic [XLEN-1:0]                     mem_resp_data,
  output logic                                wb_valid,
  output mem_exec_unit_pkg::micro_op_t        wb_uop,
  output logic [XLEN-1:0]                     wb_data,
  output logic                                wb_misaligned,
  output mem_exec_unit_pkg::mem_exec_state_t  state_dbg
);
  import mem_exec_unit_pkg::*;

  // MEM_TIMEOUT is reserved; the unit always waits for the load response.
  if (MEM_TIMEOUT != 0) begin : g_timeout_reserved
  end

  mem_exec_state_t state, state_next;
  micro_op_t       uop_q;
  logic [XLEN-1:0] addr_q, rs2_q, load_q;
  logic            mis_q;

  logic [XLEN-1:0] addr_in;
  logic            accept, in_is_mem, store_q, req_hs;
  logic [1:0]      al_addr;
  mem_size_t       al_size;
  logic [3:0]      al_wstrb;
  logic [XLEN-1:0] al_wdata, al_load;
  logic            al_mis;

  assign addr_in   = rs1_data + uop_in.imm;
  assign accept    = (state == IDLE) && uop_in.valid && !clear_en;
  assign in_is_mem = is_mem_op(uop_in.mem_type);
  assign store_q   = (uop_q.mem_type == MEM_ST);
  assign req_hs    = (state == REQ) && mem_req_ready;

  // One aligner serves both the accept-time misalignment check (IDLE) and the
  // captured access afterwards.
  assign al_addr = (state == IDLE) ? addr_in[1:0] : addr_q[1:0];
  assign al_size = (state == IDLE) ? uop_in.mem_size : uop_q.mem_size;

  mem_align_unit u_align (
    .addr_lo    (al_addr),
    .mem_size   (al_size),
    .store_data (rs2_q),
    .load_word  (mem_resp_data),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misaligned (al_mis)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!in_is_mem || al_mis) state_next = WB;
          else                      state_next = REQ;
        end
      end
      REQ: begin
        if (req_hs) begin
          if (store_q) state_next = clear_en ? IDLE : WB;
          else         state_next = clear_en ? DRAIN : WAIT;
        end else if (clear_en) begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (mem_resp_valid) state_next = clear_en ? IDLE : WB;
        else if (clear_en)  state_next = DRAIN;
      end
      WB:    state_next = IDLE;
      DRAIN: if (mem_resp_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      uop_q  <= '0;
      addr_q <= '0;
      rs2_q  <= '0;
      load_q <= '0;
      mis_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        uop_q  <= uop_in;
        addr_q <= addr_in;
        rs2_q  <= rs2_data;
        load_q <= '0;
        mis_q  <= al_mis && in_is_mem;
      end else if (clear_en && state_next == IDLE) begin
        uop_q  <= '0;
        addr_q <= '0;
        rs2_q  <= '0;
        load_q <= '0;
        mis_q  <= 1'b0;
      end else if (state == WAIT && mem_resp_valid) begin
        load_q <= al_load;
      end
    end
  end

  // Request fields are driven only in REQ and stay constant there because they
  // derive solely from captured registers.
  always_comb begin
    ex_busy       = (state != IDLE);
    mem_req_valid = (state == REQ);
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    mem_req_wstrb = 4'b0000;
    if (state == REQ) begin
      mem_req_we    = store_q;
      mem_req_addr  = {addr_q[XLEN-1:2], 2'b00};
      mem_req_wdata = store_q ? al_wdata : '0;
      mem_req_wstrb = store_q ? al_wstrb : 4'b0000;
    end
    wb_valid      = (state == WB) && !clear_en;
    wb_uop        = wb_valid ? uop_q : '0;
    wb_data       = wb_valid ? load_q : '0;
    wb_misaligned = wb_valid && mis_q;
    state_dbg     = state;
  end

endmodule

// File: tb/tb_mem_exec_unit.sv
// Bench for mem_exec_unit: directed scenarios plus randomized accesses checked
// against a byte-level reference model.
module tb_mem_exec_unit;
  import mem_exec_unit_pkg::*;

  logic            clock = 1'b0;
  logic            reset, clear_en;
  micro_op_t       uop_in;
  logic [31:0]     rs1_data, rs2_data;
  logic            ex_busy, mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0]     mem_req_addr, mem_req_wdata;
  logic [3:0]      mem_req_wstrb;
  logic            mem_resp_valid;
  logic [31:0]     mem_resp_data;
  logic            wb_valid, wb_misaligned;
  micro_op_t       wb_uop;
  logic [31:0]     wb_data;
  mem_exec_state_t state_dbg;
  logic [255:0]    all_outs;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    int          req_cycles;
    int          req_count;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    bit          stable;
    int          wb_count;
    int          wb_cycle;
    logic [31:0] wb_data;
    logic        wb_mis;
    micro_op_t   wb_uop;
    bit          busy_ok;
  } obs_t;

  mem_exec_unit #(.XLEN(32), .MEM_TIMEOUT(0)) dut (
    .clock(clock), .reset(reset), .clear_en(clear_en), .uop_in(uop_in),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_busy(ex_busy),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .wb_valid(wb_valid), .wb_uop(wb_uop), .wb_data(wb_data),
    .wb_misaligned(wb_misaligned), .state_dbg(state_dbg)
  );

  assign all_outs = 256'({ex_busy, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
                          mem_req_wstrb, wb_valid, wb_uop, wb_data, wb_misaligned});

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int size_bytes(mem_size_t s);
    case (s)
      MEM_B, MEM_BU: return 1;
      MEM_H, MEM_HU: return 2;
      default:       return 4;
    endcase
  endfunction

  function automatic bit model_mis(mem_type_t t, mem_size_t s, logic [31:0] addr);
    return (t == MEM_LD || t == MEM_ST) && ((addr % size_bytes(s)) != 0);
  endfunction

  function automatic logic [3:0] model_strb(mem_size_t s, logic [31:0] addr);
    int m;
    m = ((1 << size_bytes(s)) - 1) << (addr % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] model_wdata(mem_size_t s, logic [31:0] rs2);
    logic [31:0] r;
    int nb;
    nb = size_bytes(s);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = rs2[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(mem_size_t s, logic [31:0] addr, logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * (addr % 4));
    if (size_bytes(s) == 1) begin
      v = v & 32'hFF;
      if (s == MEM_B && v >= 32'd128) v = v - 32'd256;
    end else if (size_bytes(s) == 2) begin
      v = v & 32'hFFFF;
      if (s == MEM_H && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  function automatic micro_op_t make_op(mem_type_t t, mem_size_t s, logic [31:0] imm, logic [5:0] rob);
    micro_op_t u;
    u = '0;
    u.valid = 1'b1; u.mem_type = t; u.mem_size = s; u.imm = imm; u.rob_idx = rob; u.pdst = 7'(rob) + 7'd1;
    return u;
  endfunction

  // ---------------- driver ----------------
  // Presents one uop in an IDLE cycle (cycle 0), then runs cycles 1.. with
  // ready low for ready_delay cycles and a response resp_delay cycles after the
  // request handshake; stops one cycle after writeback.
  task automatic run_op(input micro_op_t op, input logic [31:0] rs1, input logic [31:0] rs2,
                        input int ready_delay, input int resp_delay, input logic [31:0] resp_word,
                        output obs_t o);
    int hs_c;
    o.req_cycles = 0; o.req_count = 0; o.req_addr = '0; o.req_we = 1'b0; o.req_wdata = '0;
    o.req_wstrb = '0; o.stable = 1'b1; o.wb_count = 0; o.wb_cycle = 0; o.wb_data = '0;
    o.wb_mis = 1'b0; o.wb_uop = '0; o.busy_ok = 1'b1;
    hs_c = 0;
    @(posedge clock); #1;
    uop_in = op; rs1_data = rs1; rs2_data = rs2; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    @(negedge clock);
    for (int c = 1; c <= 60; c++) begin
      @(posedge clock); #1;
      uop_in = '0; rs1_data = $urandom; rs2_data = $urandom;
      mem_req_ready  = (c > ready_delay);
      mem_resp_valid = (hs_c != 0) && (c == hs_c + resp_delay);
      mem_resp_data  = mem_resp_valid ? resp_word : $urandom;
      @(negedge clock);
      if (o.wb_count != 0 && c == o.wb_cycle + 1) begin
        if (ex_busy !== 1'b0 || wb_valid !== 1'b0) o.busy_ok = 1'b0;
        break;
      end
      if (ex_busy !== 1'b1) o.busy_ok = 1'b0;
      if (mem_req_valid === 1'b1) begin
        if (o.req_cycles == 0) begin
          o.req_addr = mem_req_addr; o.req_we = mem_req_we;
          o.req_wdata = mem_req_wdata; o.req_wstrb = mem_req_wstrb;
        end else if (mem_req_addr !== o.req_addr || mem_req_we !== o.req_we ||
                     mem_req_wdata !== o.req_wdata || mem_req_wstrb !== o.req_wstrb) begin
          o.stable = 1'b0;
        end
        o.req_cycles++;
        if (mem_req_ready) begin o.req_count++; hs_c = c; end
      end
      if (wb_valid === 1'b1) begin
        o.wb_count++; o.wb_cycle = c; o.wb_data = wb_data; o.wb_mis = wb_misaligned; o.wb_uop = wb_uop;
      end
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; clear_en = 1'b0; uop_in = '0; rs1_data = '0; rs2_data = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    n_checks++; if (all_outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_outs); end
    n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE); end
  endtask

  task automatic test_lw();
    obs_t o;
    micro_op_t op;
    op = make_op(MEM_LD, MEM_W, 32'd4, 6'd5);
    run_op(op, 32'h1000, $urandom, 0, 2, 32'hDEADBEEF, o);
    n_checks++; if (o.req_addr !== 32'h1004) begin n_fail++; $display("FAIL lw_addr: got %h expected %h", o.req_addr, 32'h1004); end
    n_checks++; if (o.req_we !== 1'b0) begin n_fail++; $display("FAIL lw_we: got %b expected 0", o.req_we); end
    n_checks++; if (o.wb_count != 1 || o.wb_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %0d x %h expected 1 x deadbeef", o.wb_count, o.wb_data); end
    n_checks++; if (o.wb_cycle != 4) begin n_fail++; $display("FAIL lw_latency: got %0d expected 4", o.wb_cycle); end
    n_checks++; if (!o.busy_ok) begin n_fail++; $display("FAIL lw_busy: got wrong ex_busy expected high until after wb"); end
    n_checks++; if (o.wb_uop !== op) begin n_fail++; $display("FAIL lw_uop: got %h expected %h", o.wb_uop, op); end
  endtask

  task automatic test_lb_sign();
    obs_t o;
    run_op(make_op(MEM_LD, MEM_B, 32'd3, 6'd1), 32'h1000, 32'h0, 0, 1, 32'h80FF_0000, o);
    n_checks++; if (o.wb_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_sext: got %h expected ffffff80", o.wb_data); end
    n_checks++; if (o.req_addr !== 32'h1000) begin n_fail++; $display("FAIL lb_addr: got %h expected 00001000", o.req_addr); end
    run_op(make_op(MEM_LD, MEM_BU, 32'd3, 6'd2), 32'h1000, 32'h0, 1, 3, 32'h80FF_0000, o);
    n_checks++; if (o.wb_data !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_zext: got %h expected 00000080", o.wb_data); end
  endtask

  task automatic test_sh_stall();
    obs_t o;
    run_op(make_op(MEM_ST, MEM_H, 32'd2, 6'd9), 32'h2000, 32'h1234ABCD, 3, 1, 32'h0, o);
    n_checks++; if (o.req_wstrb !== 4'b1100) begin n_fail++; $display("FAIL sh_wstrb: got %b expected 1100", o.req_wstrb); end
    n_checks++; if (o.req_wdata !== 32'hABCDABCD) begin n_fail++; $display("FAIL sh_wdata: got %h expected abcdabcd", o.req_wdata); end
    n_checks++; if (o.req_we !== 1'b1 || o.req_addr !== 32'h2000) begin n_fail++; $display("FAIL sh_req: got we=%b addr=%h expected we=1 addr=00002000", o.req_we, o.req_addr); end
    n_checks++; if (!o.stable || o.req_cycles != 4) begin n_fail++; $display("FAIL sh_hold: got stable=%0d cycles=%0d expected 1/4", o.stable, o.req_cycles); end
    n_checks++; if (o.wb_cycle != 5 || o.wb_data !== 32'h0) begin n_fail++; $display("FAIL sh_wb: got cycle=%0d data=%h expected 5/0", o.wb_cycle, o.wb_data); end
  endtask

  task automatic test_misaligned();
    obs_t o;
    run_op(make_op(MEM_LD, MEM_W, 32'd1, 6'd3), 32'h1000, 32'h0, 0, 1, 32'h5555_5555, o);
    n_checks++; if (o.req_cycles != 0) begin n_fail++; $display("FAIL mis_noreq: got %0d req cycles expected 0", o.req_cycles); end
    n_checks++; if (o.wb_mis !== 1'b1 || o.wb_data !== 32'h0) begin n_fail++; $display("FAIL mis_wb: got mis=%b data=%h expected 1/0", o.wb_mis, o.wb_data); end
    n_checks++; if (o.wb_cycle != 1) begin n_fail++; $display("FAIL mis_latency: got %0d expected 1", o.wb_cycle); end
  endtask

  task automatic test_nop();
    obs_t o;
    run_op(make_op(MEM_NONE, MEM_W, 32'd0, 6'd7), 32'h4000, 32'h1, 0, 1, 32'h0, o);
    n_checks++; if (o.req_cycles != 0 || o.wb_count != 1 || o.wb_mis !== 1'b0) begin n_fail++; $display("FAIL nop: got req=%0d wb=%0d mis=%b expected 0/1/0", o.req_cycles, o.wb_count, o.wb_mis); end
  endtask

  task automatic test_clear_wait();
    obs_t o;
    int wb_seen = 0;
    int busy_bad = 0;
    @(posedge clock); #1;
    uop_in = make_op(MEM_LD, MEM_W, 32'd8, 6'd11); rs1_data = 32'h3000; mem_req_ready = 1'b1;
    @(negedge clock);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clock); #1;
      uop_in = '0;
      clear_en = (c == 2);
      mem_resp_valid = (c == 6);
      mem_resp_data = $urandom;
      @(negedge clock);
      if (wb_valid === 1'b1) wb_seen++;
      if (c <= 6 && ex_busy !== 1'b1) busy_bad++;
      if (c >= 7 && ex_busy !== 1'b0) busy_bad++;
    end
    clear_en = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    n_checks++; if (wb_seen != 0) begin n_fail++; $display("FAIL clear_wait_wb: got %0d wb pulses expected 0", wb_seen); end
    n_checks++; if (busy_bad != 0) begin n_fail++; $display("FAIL clear_wait_busy: got %0d bad cycles expected 0", busy_bad); end
    run_op(make_op(MEM_LD, MEM_HU, 32'd2, 6'd12), 32'h3000, 32'h0, 0, 1, 32'hBEEF_1234, o);
    n_checks++; if (o.wb_data !== 32'h0000_BEEF) begin n_fail++; $display("FAIL clear_wait_next: got %h expected 0000beef", o.wb_data); end
  endtask

  task automatic test_clear_req();
    int bad = 0;
    @(posedge clock); #1;
    uop_in = make_op(MEM_ST, MEM_W, 32'd0, 6'd13); rs1_data = 32'h5000; rs2_data = 32'h77;
    mem_req_ready = 1'b0;
    @(negedge clock);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clock); #1;
      uop_in = '0;
      clear_en = (c == 2);
      mem_req_ready = (c >= 3);
      @(negedge clock);
      if (c <= 2 && mem_req_valid !== 1'b1) bad++;
      if (c >= 3 && (mem_req_valid !== 1'b0 || ex_busy !== 1'b0)) bad++;
      if (wb_valid !== 1'b0) bad++;
    end
    clear_en = 1'b0; mem_req_ready = 1'b0;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL clear_req: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_reset_in_req();
    @(posedge clock); #1;
    uop_in = make_op(MEM_ST, MEM_B, 32'd1, 6'd14); rs1_data = 32'h6000; rs2_data = 32'hA5;
    mem_req_ready = 1'b0;
    @(negedge clock);
    @(posedge clock); #1;
    uop_in = '0; reset = 1'b1;
    @(negedge clock);
    n_checks++; if (mem_req_valid !== 1'b1 || mem_req_wstrb !== 4'b0010) begin n_fail++; $display("FAIL rst_req_pre: got valid=%b strb=%b expected 1/0010", mem_req_valid, mem_req_wstrb); end
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if (all_outs !== '0 || state_dbg !== IDLE) begin n_fail++; $display("FAIL rst_in_req: got outs=%h state=%0d expected 0/0", all_outs, state_dbg); end
  endtask

  task automatic test_back_to_back();
    int wb_n = 0;
    int first_wb = 0;
    int last_wb = 0;
    int hs_n = 0;
    int addr_bad = 0;
    @(posedge clock); #1;
    uop_in = make_op(MEM_ST, MEM_W, 32'h10, 6'd20); rs1_data = 32'h7000; rs2_data = 32'hCAFE_F00D;
    mem_req_ready = 1'b1;
    @(negedge clock);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clock); #1;
      if (c == 12) uop_in = '0;
      @(negedge clock);
      if (mem_req_valid === 1'b1 && mem_req_ready) begin
        hs_n++;
        if (mem_req_addr !== 32'h7010 || mem_req_wdata !== 32'hCAFE_F00D) addr_bad++;
      end
      if (wb_valid === 1'b1) begin
        wb_n++; last_wb = c;
        if (first_wb == 0) first_wb = c;
      end
    end
    mem_req_ready = 1'b0;
    n_checks++; if (wb_n != 4 || first_wb != 2 || last_wb != 11) begin n_fail++; $display("FAIL b2b_wb: got n=%0d first=%0d last=%0d expected 4/2/11", wb_n, first_wb, last_wb); end
    n_checks++; if (hs_n != 4 || addr_bad != 0) begin n_fail++; $display("FAIL b2b_req: got hs=%0d bad=%0d expected 4/0", hs_n, addr_bad); end
  endtask

  task automatic test_random();
    mem_size_t sizes[5] = '{MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU};
    for (int i = 0; i < 40; i++) begin
      obs_t        o;
      micro_op_t   op;
      mem_type_t   t;
      logic [31:0] rs1, rs2, imm, word, addr, exp_data;
      int          rd, pd, r, exp_req, exp_cyc;
      bit          mis;
      r = $urandom_range(0, 9);
      t = (r == 0) ? MEM_NONE : (r <= 5) ? MEM_LD : MEM_ST;
      rs1 = $urandom; rs2 = $urandom; imm = $urandom_range(0, 4095); word = $urandom;
      rd = $urandom_range(0, 3); pd = $urandom_range(1, 4);
      op = make_op(t, sizes[$urandom_range(0, 4)], imm, 6'(i));
      addr = rs1 + imm;
      mis = model_mis(t, op.mem_size, addr);
      exp_req = (t != MEM_NONE && !mis) ? 1 : 0;
      exp_cyc = (exp_req == 0) ? 1 : (t == MEM_ST) ? rd + 2 : rd + pd + 2;
      exp_q.push_back((t == MEM_LD && !mis) ? model_load(op.mem_size, addr, word) : 32'h0);
      run_op(op, rs1, rs2, rd, pd, word, o);
      exp_data = exp_q.pop_front();
      n_checks++; if (o.wb_count != 1 || o.wb_data !== exp_data) begin n_fail++; $display("FAIL rnd%0d_data: got %0d x %h expected 1 x %h", i, o.wb_count, o.wb_data, exp_data); end
      n_checks++; if (o.wb_mis !== mis || o.wb_uop !== op) begin n_fail++; $display("FAIL rnd%0d_wb: got mis=%b uop=%h expected %b/%h", i, o.wb_mis, o.wb_uop, mis, op); end
      n_checks++; if (o.req_count != exp_req || o.wb_cycle != exp_cyc || !o.busy_ok || !o.stable) begin n_fail++; $display("FAIL rnd%0d_timing: got req=%0d cyc=%0d busy=%0d stable=%0d expected %0d/%0d/1/1", i, o.req_count, o.wb_cycle, o.busy_ok, o.stable, exp_req, exp_cyc); end
      if (exp_req == 1) begin
        n_checks++; if (o.req_addr !== (addr & 32'hFFFF_FFFC) || o.req_we !== (t == MEM_ST)) begin n_fail++; $display("FAIL rnd%0d_addr: got %h we=%b expected %h", i, o.req_addr, o.req_we, addr & 32'hFFFF_FFFC); end
        if (t == MEM_ST) begin
          n_checks++; if (o.req_wstrb !== model_strb(op.mem_size, addr) || o.req_wdata !== model_wdata(op.mem_size, rs2)) begin n_fail++; $display("FAIL rnd%0d_store: got %b/%h expected %b/%h", i, o.req_wstrb, o.req_wdata, model_strb(op.mem_size, addr), model_wdata(op.mem_size, rs2)); end
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_lw();
    test_lb_sign();
    test_sh_stall();
    test_misaligned();
    test_nop();
    test_clear_wait();
    test_clear_req();
    test_reset_in_req();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
